pwm_audio_out: RTL and testbench
================================

# pwm_audio_out

PWM audio output stage that consumes the free-running period count and turns a stream of unsigned samples into a single-bit pulse-width-modulated line for the board's audio jack. It sits directly downstream of the shared period `counter`, which it instantiates as its frame timebase. Upstream, the demodulator/resampler path feeds it through a valid/ready handshake. It holds each sample for a fixed number of PWM frames, double-buffers the next sample, and reports underruns.

## Interface
- `SAMPLE_WIDTH`, 8: sample width W; PWM frame length is PERIOD = 2**W clocks.
- `FRAMES_PER_SAMPLE`, 4: number of PWM frames each sample is held; must be ≥1.
- `clk_in`  input  1: system clock; single clock domain.
- `rst_in`  input  1: reset, asynchronous, active-high.
- `enable_in`  input  1: run request; low forces IDLE.
- `sample_in`  input  W: unsigned sample, duty = sample/PERIOD.
- `sample_valid_in`  input  1: sample_in valid.
- `sample_ready_out`  output  1: block accepts a sample this cycle.
- `clear_underrun_in`  input  1: clears sticky underrun flag.
- `pwm_out`  output  1: registered PWM line.
- `frame_strobe_out`  output  1: one-cycle pulse on the last cycle of each frame.
- `underrun_out`  output  1: sticky underrun flag.

## Operation
- Reset values: pwm_out=0, frame_strobe_out=0, underrun_out=0, sample_ready_out=0. State=IDLE. Active and pending registers are 0; pending is empty; frame_cnt=0.
- States:
  - IDLE: ready=0; pwm_out=0; counter held at 0. Go to PRIME when enable_in=1.
  - PRIME: ready=1. On accept, sample goes straight to active and the state moves to RUN. Counter is held at 0, so the first RUN cycle has count=0.
  - RUN: ready = !pending_full. An accepted sample goes to pending.
  - Any state, enable_in=0: go to IDLE next cycle, flush pending, zero active and frame_cnt. Underrun flag is retained.
- Accept = sample_valid_in && sample_ready_out.
- Counter: period_in = PERIOD (zero-extended to 32 bits). Its synchronous reset is driven high whenever the state is not RUN.
- Frame end: count == PERIOD-1.
  - If frame_cnt < F-1: frame_cnt++.
  - Otherwise frame_cnt ← 0 and a sample swap occurs:
    - pending full: active ← pending, pending empties.
    - pending empty: active unchanged (last sample repeats), underrun_out ← 1.
- Accept in the same cycle as a swap with pending empty: the accepted sample lands in pending, the underrun is still flagged, and the sample is used at the next swap.
- Swap with pending full: ready was 0, so no accept can collide with it.
- Underrun flag: set and clear_underrun_in in the same cycle → set wins.
- Comparison uses W+1-bit unsigned arithmetic against the low bits of count_out. The upper counter bits are always 0.

## Timing
- pwm_out registered: pwm_out(t+1) = RUN && (count(t) < active(t)).
  - High for exactly `active` cycles per frame.
  - 0 → never high; 2**W-1 → low one cycle per frame.
- frame_strobe_out registered from the frame-end condition, so it aligns with pwm_out's last frame cycle.
- Accept to pwm effect:
  - PRIME: first frame starts the cycle after accept; pwm_out reflects the sample one cycle later.
  - RUN: takes effect at the next swap boundary.
- Sample period = F·PERIOD clocks. Sustained throughput is one sample per sample period.
- Async reset mid-frame: all outputs drop immediately; the state returns to IDLE.

## Structure
- `pwm_audio_pkg`: state enum typedef (IDLE, PRIME, RUN) and default width/frame constants.
- One sub-module: the shared `counter` as frame timebase. All other logic is local FSM, holding registers and comparator.

## Test plan
- W=8, F=4, enable, accept 0x40: pwm_out high 64 of each 256 cycles, 4 frames, strobe every 256 cycles; underrun_out stays 0.
- Feed 0x00 then 0xFF back-to-back: frames 0-3 pwm_out never high; frames 4-7 high 255 cycles, low 1.
- Single sample 0x80, no further valid: after 4 frames underrun_out=1, pwm_out keeps 128/256 duty; assert clear_underrun_in → 0.
- Valid held high continuously: ready drops after pending fills and reasserts the cycle after each swap. No sample lost or duplicated (check sequence 1,2,3,4).
- Deassert enable_in mid-frame: next cycle IDLE, pwm_out=0, ready=0; re-enable requires a new sample via PRIME.
- Async rst_in pulse mid-frame, between clock edges: all outputs 0 immediately; after release state IDLE, counter count 0.

Source files
------------

// File: rtl/pwm_audio_out_pkg.sv
// Shared types and defaults for the PWM audio output stage.
package pwm_audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int DEFAULT_SAMPLE_WIDTH      = 8;
    localparam int DEFAULT_FRAMES_PER_SAMPLE = 4;

    // Width of the frame-within-sample counter; never narrower than one bit.
    function automatic int frame_cnt_width(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

endpackage

// File: rtl/pwm_audio_out_if.sv
// Sample stream handshake between the resampler path and the PWM stage.
interface pwm_audio_out_if
    import pwm_audio_pkg::*;
    #(parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH);

    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_valid_in;
    logic                    sample_ready_out;

    modport master (
        output sample_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  sample_in,
        input  sample_valid_in,
        output sample_ready_out
    );

endinterface

// File: rtl/pwm_audio_out_counter.sv
// Shared free-running period counter: counts 0 .. period_in-1 and wraps.
module counter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sync_rst_in,
    input  logic [31:0] period_in,
    output logic [31:0] count_out
);

    // Count up, wrapping on the last cycle of the period; the synchronous
    // reset parks the count at zero so the owner controls where a frame starts.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (sync_rst_in) begin
            count_out <= '0;
        end else if (count_out + 32'd1 >= period_in) begin
            count_out <= '0;
        end else begin
            count_out <= count_out + 32'd1;
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: holds each sample for a fixed number of PWM
// frames, double-buffers the next one and flags underruns.
module pwm_audio_out
    import pwm_audio_pkg::*;
    #(
        parameter int SAMPLE_WIDTH      = DEFAULT_SAMPLE_WIDTH,
        parameter int FRAMES_PER_SAMPLE = DEFAULT_FRAMES_PER_SAMPLE
    ) (
        input  logic               clk_in,
        input  logic               rst_in,
        input  logic               enable_in,
        input  logic               clear_underrun_in,
        pwm_audio_out_if.slave     sample_if,
        output logic               pwm_out,
        output logic               frame_strobe_out,
        output logic               underrun_out
    );

    localparam int                 FCW        = frame_cnt_width(FRAMES_PER_SAMPLE);
    localparam logic [31:0]        PERIOD     = 32'd1 << SAMPLE_WIDTH;
    localparam logic [FCW-1:0]     LAST_FRAME = FCW'(FRAMES_PER_SAMPLE - 1);

    state_t                  state;
    state_t                  next_state;
    logic [SAMPLE_WIDTH-1:0] active_q;
    logic [SAMPLE_WIDTH-1:0] pending_q;
    logic                    pending_full;
    logic [FCW-1:0]          frame_cnt;
    logic [31:0]             count;
    logic                    in_run;
    logic                    frame_end;
    logic                    swap;
    logic                    accept;
    logic                    sample_ready;

    assign in_run    = (state == RUN);
    assign frame_end = in_run && (count == PERIOD - 32'd1);
    assign swap      = frame_end && (frame_cnt == LAST_FRAME);
    assign accept    = sample_if.sample_valid_in && sample_ready;

    assign sample_if.sample_ready_out = sample_ready;

    // Frame timebase; held at zero outside RUN so the first RUN cycle is count 0.
    counter u_counter (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .sync_rst_in (!in_run),
        .period_in   (PERIOD),
        .count_out   (count)
    );

    // Ready depends only on state: PRIME always takes the first sample,
    // RUN takes one more while the pending slot is free.
    always_comb begin
        sample_ready = 1'b0;
        case (state)
            PRIME:   sample_ready = 1'b1;
            RUN:     sample_ready = !pending_full;
            default: sample_ready = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        next_state = state;
        if (!enable_in) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = PRIME;
                PRIME:   next_state = accept ? RUN : PRIME;
                RUN:     next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    // Active/pending sample buffers and frame counter; the swap is applied
    // before the accept so a same-cycle accept still lands in pending.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active_q     <= '0;
            pending_q    <= '0;
            pending_full <= 1'b0;
            frame_cnt    <= '0;
        end else if (!enable_in) begin
            active_q     <= '0;
            pending_q    <= '0;
            pending_full <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            if ((state == PRIME) && accept) begin
                active_q <= sample_if.sample_in;
            end
            if (frame_end) begin
                frame_cnt <= swap ? '0 : frame_cnt + FCW'(1);
            end
            if (swap && pending_full) begin
                active_q     <= pending_q;
                pending_full <= 1'b0;
            end
            if (in_run && accept) begin
                pending_q    <= sample_if.sample_in;
                pending_full <= 1'b1;
            end
        end
    end

    // Sticky underrun: a swap with nothing pending sets it, and a set in the
    // same cycle as a clear wins.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            underrun_out <= 1'b0;
        end else if (enable_in && swap && !pending_full) begin
            underrun_out <= 1'b1;
        end else if (clear_underrun_in) begin
            underrun_out <= 1'b0;
        end
    end

    // Registered PWM line and frame strobe; forced low as soon as enable drops.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pwm_out          <= 1'b0;
            frame_strobe_out <= 1'b0;
        end else begin
            pwm_out          <= enable_in && in_run &&
                                (count[SAMPLE_WIDTH:0] < {1'b0, active_q});
            frame_strobe_out <= enable_in && frame_end;
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out (W=8, F=4) with a behavioural model.
module tb_pwm_audio_out;
    import pwm_audio_pkg::*;

    localparam int W      = 8;
    localparam int F      = 4;
    localparam int PERIOD = 256;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic enable_in = 1'b0;
    logic clear_underrun_in = 1'b0;
    logic pwm_out;
    logic frame_strobe_out;
    logic underrun_out;

    int checks = 0;
    int failures = 0;

    pwm_audio_out_if #(.SAMPLE_WIDTH(W)) s_if ();

    pwm_audio_out #(.SAMPLE_WIDTH(W), .FRAMES_PER_SAMPLE(F)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .enable_in         (enable_in),
        .clear_underrun_in (clear_underrun_in),
        .sample_if         (s_if),
        .pwm_out           (pwm_out),
        .frame_strobe_out  (frame_strobe_out),
        .underrun_out      (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: time since RUN began, a queue for the waiting sample.
    bit m_primed;
    bit m_running;
    int m_tick;
    int m_active;
    int m_pend[$];
    bit m_und;
    bit e_pwm;
    bit e_strobe;

    function automatic bit model_ready();
        if (m_primed) return 1'b1;
        if (m_running) return (m_pend.size() == 0);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_primed  = 0;
        m_running = 0;
        m_tick    = 0;
        m_active  = 0;
        m_pend.delete();
        m_und     = 0;
        e_pwm     = 0;
        e_strobe  = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit fend;
        bit set_und;
        int pos;
        acc     = s_if.sample_valid_in && model_ready();
        pos     = m_tick % PERIOD;
        fend    = m_running && (pos == PERIOD - 1);
        set_und = 0;
        e_pwm    = enable_in && m_running && (pos < m_active);
        e_strobe = enable_in && fend;
        if (!enable_in) begin
            m_primed  = 0;
            m_running = 0;
            m_active  = 0;
            m_tick    = 0;
            m_pend.delete();
        end else if (!m_primed && !m_running) begin
            m_primed = 1;
        end else if (m_primed) begin
            if (acc) begin
                m_active  = int'(s_if.sample_in);
                m_primed  = 0;
                m_running = 1;
                m_tick    = 0;
            end
        end else begin
            if (fend && ((m_tick / PERIOD) % F == F - 1)) begin
                if (m_pend.size() > 0) m_active = m_pend.pop_front();
                else set_und = 1;
            end
            if (acc) m_pend.push_back(int'(s_if.sample_in));
            m_tick++;
        end
        if (set_und) m_und = 1;
        else if (clear_underrun_in) m_und = 0;
    endtask

    initial model_reset();

    // Async reset clears the model at the moment it is asserted.
    always @(posedge rst_in) model_reset();

    // Advance the model on every edge and compare shortly after it.
    always @(posedge clk_in) begin
        if (rst_in) begin
            model_reset();
        end else begin
            model_step();
            #1;
            if (!rst_in) begin
                check_output("model_pwm", pwm_out, e_pwm);
                check_output("model_strobe", frame_strobe_out, e_strobe);
                check_output("model_underrun", underrun_out, m_und);
                check_output("model_ready", s_if.sample_ready_out, model_ready());
            end
        end
    end

    // Present one sample and wait (bounded) until it is accepted.
    task automatic apply_stimulus(input logic [7:0] s);
        bit done;
        done = 0;
        @(negedge clk_in);
        s_if.sample_in = s;
        s_if.sample_valid_in = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (s_if.sample_ready_out) begin
                @(posedge clk_in);
                done = 1;
            end else begin
                @(negedge clk_in);
            end
        end
        check_output("accept_within_bound", done, 1);
        #1;
        s_if.sample_valid_in = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int hi, output int strobes);
        hi = 0;
        strobes = 0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
            hi += int'(pwm_out);
            strobes += int'(frame_strobe_out);
        end
    endtask

    task automatic stop_run();
        @(negedge clk_in);
        enable_in = 1'b0;
        s_if.sample_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        clear_underrun_in = 1'b1;
        @(negedge clk_in);
        clear_underrun_in = 1'b0;
        @(negedge clk_in);
        enable_in = 1'b1;
    endtask

    initial begin
        int hi, st, hi2, st2;
        int buckets[4];
        int seq[4];
        int idx, k;
        bit acc, started, und_pre, und_end;

        s_if.sample_in = '0;
        s_if.sample_valid_in = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk_in);
        #1;
        check_output("reset_pwm", pwm_out, 0);
        check_output("reset_strobe", frame_strobe_out, 0);
        check_output("reset_underrun", underrun_out, 0);
        check_output("reset_ready", s_if.sample_ready_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        enable_in = 1'b1;

        // Duty 0x40 over one sample period.
        apply_stimulus(8'h40);
        run_cycles(1023, hi, st);
        check_output("x40_no_underrun", underrun_out, 0);
        run_cycles(1, hi2, st2);
        check_output("x40_high_cycles", hi + hi2, 4 * 64);
        check_output("x40_strobes", st + st2, 4);
        stop_run();

        // 0x00 then 0xFF back to back.
        apply_stimulus(8'h00);
        s_if.sample_in = 8'hFF;
        s_if.sample_valid_in = 1'b1;
        hi = 0;
        hi2 = 0;
        for (int c = 1; c <= 2048; c++) begin
            @(posedge clk_in);
            #1;
            if (c == 1) s_if.sample_valid_in = 1'b0;
            if (c <= 1024) hi += int'(pwm_out);
            else hi2 += int'(pwm_out);
        end
        check_output("x00_high_cycles", hi, 0);
        check_output("xFF_high_cycles", hi2, 4 * 255);
        stop_run();

        // Single sample then underrun, repeat, clear.
        apply_stimulus(8'h80);
        run_cycles(1024, hi, st);
        check_output("underrun_set", underrun_out, 1);
        run_cycles(256, hi, st);
        check_output("x80_repeat_high", hi, 128);
        @(negedge clk_in);
        clear_underrun_in = 1'b1;
        @(negedge clk_in);
        clear_underrun_in = 1'b0;
        check_output("underrun_cleared", underrun_out, 0);
        stop_run();

        // Valid held high across four samples.
        seq = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++) buckets[i] = 0;
        idx = 0;
        k = 0;
        started = 0;
        und_pre = 0;
        und_end = 0;
        s_if.sample_in = 8'(seq[0]);
        s_if.sample_valid_in = 1'b1;
        for (int c = 0; c < 9000 && k < 4096; c++) begin
            @(negedge clk_in);
            acc = s_if.sample_ready_out && s_if.sample_valid_in;
            @(posedge clk_in);
            #1;
            if (started) begin
                buckets[k / 1024] += int'(pwm_out);
                if (k == 4094) und_pre = underrun_out;
                if (k == 4095) und_end = underrun_out;
                k++;
            end
            if (acc) begin
                idx++;
                if (idx == 1) started = 1;
                if (idx < 4) s_if.sample_in = 8'(seq[idx]);
                else s_if.sample_valid_in = 1'b0;
            end
        end
        s_if.sample_valid_in = 1'b0;
        check_output("stream_finished_in_bound", k, 4096);
        check_output("stream_accepts", idx, 4);
        for (int i = 0; i < 4; i++) check_output($sformatf("stream_high_%0d", i), buckets[i], 4 * seq[i]);
        check_output("stream_no_early_underrun", und_pre, 0);
        check_output("stream_final_underrun", und_end, 1);
        stop_run();

        // Deassert enable mid-frame.
        apply_stimulus(8'hFF);
        run_cycles(100, hi, st);
        check_output("pre_disable_pwm", pwm_out, 1);
        @(negedge clk_in);
        enable_in = 1'b0;
        @(posedge clk_in);
        #1;
        check_output("disable_pwm", pwm_out, 0);
        check_output("disable_ready", s_if.sample_ready_out, 0);
        @(negedge clk_in);
        enable_in = 1'b1;
        run_cycles(300, hi, st);
        check_output("reenable_no_pwm", hi, 0);
        check_output("reenable_ready", s_if.sample_ready_out, 1);

        // Async reset mid-frame.
        apply_stimulus(8'hFF);
        run_cycles(1100, hi, st);
        check_output("pre_reset_underrun", underrun_out, 1);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check_output("async_pwm", pwm_out, 0);
        check_output("async_strobe", frame_strobe_out, 0);
        check_output("async_underrun", underrun_out, 0);
        check_output("async_ready", s_if.sample_ready_out, 0);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        check_output("post_reset_ready", s_if.sample_ready_out, 1);
        check_output("post_reset_pwm", pwm_out, 0);

        // Randomized traffic checked by the model.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk_in);
            enable_in = ($urandom_range(0, 399) != 0);
            s_if.sample_valid_in = ($urandom_range(0, 3) == 0);
            s_if.sample_in = 8'($urandom);
            clear_underrun_in = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk_in);
        s_if.sample_valid_in = 1'b0;
        clear_underrun_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
